feed_arbiter: RTL and testbench

FEED_ARBITER -- requirements
Module: feed_arbiter

---
 rtl/feed_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/feed_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_feed_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feed_pkg.sv
// Shared types for the feed arbiter: default beat geometry, beat record and FSM states.
package feed_pkg;

  localparam int C_PKT_BEAT_BYTES_DEF  = 8;
  localparam int C_PKT_DATA_WIDTH_DEF  = C_PKT_BEAT_BYTES_DEF * 8;
  localparam int C_PKT_EMPTY_WIDTH_DEF = $clog2(C_PKT_BEAT_BYTES_DEF);

  typedef struct packed {
    logic                             vld;
    logic                             sop;
    logic                             eop;
    logic [C_PKT_DATA_WIDTH_DEF-1:0]  dat;
    logic [C_PKT_EMPTY_WIDTH_DEF-1:0] emt;
    logic                             err;
  } t_pkt;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } t_state;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester strictly after the last winner, with wrap.
module rr_arbiter #(
  parameter int C_NUM_PORTS = 4,
  parameter int C_IDX_WIDTH = $clog2(C_NUM_PORTS)
) (
  input  logic [C_NUM_PORTS-1:0] req,
  input  logic [C_IDX_WIDTH-1:0] last,
  output logic [C_NUM_PORTS-1:0] gnt_onehot,
  output logic [C_IDX_WIDTH-1:0] gnt_idx,
  output logic                   gnt_any
);

  logic [C_IDX_WIDTH:0] cand_s;

  // Walk ports last+1 .. last+N modulo N and take the first request.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand_s  = '0;
    for (int i = 1; i <= C_NUM_PORTS; i++) begin
      cand_s = {1'b0, last} + (C_IDX_WIDTH + 1)'(i);
      if (cand_s >= (C_IDX_WIDTH + 1)'(C_NUM_PORTS)) begin
        cand_s = cand_s - (C_IDX_WIDTH + 1)'(C_NUM_PORTS);
      end else begin
        cand_s = cand_s;
      end
      if (!gnt_any && req[cand_s[C_IDX_WIDTH-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_s[C_IDX_WIDTH-1:0];
      end else begin
        gnt_any = gnt_any;
      end
    end
  end

  // One-hot form of the winner, empty when nobody requests.
  always_comb begin
    if (gnt_any) begin
      gnt_onehot = {{(C_NUM_PORTS-1){1'b0}}, 1'b1} << gnt_idx;
    end else begin
      gnt_onehot = '0;
    end
  end

endmodule

// File: rtl/feed_arbiter.sv
// Packet-granular round-robin merge of several Avalon-ST feed sources into one stream,
// discarding orphan beats that arrive while no packet is open.
module feed_arbiter
  import feed_pkg::*;
#(
  parameter  int C_NUM_PORTS       = 4,
  parameter  int C_PKT_BEAT_BYTES  = C_PKT_BEAT_BYTES_DEF,
  parameter  int C_DROP_CNT_WIDTH  = 16,
  localparam int C_PKT_DATA_WIDTH  = C_PKT_BEAT_BYTES * 8,
  localparam int C_PKT_EMPTY_WIDTH = $clog2(C_PKT_BEAT_BYTES),
  localparam int C_PORT_WIDTH      = $clog2(C_NUM_PORTS)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [C_NUM_PORTS-1:0]                    in_valid,
  input  logic [C_NUM_PORTS-1:0]                    in_startofpacket,
  input  logic [C_NUM_PORTS-1:0]                    in_endofpacket,
  input  logic [C_NUM_PORTS-1:0]                    in_error,
  input  logic [C_NUM_PORTS*C_PKT_DATA_WIDTH-1:0]   in_data,
  input  logic [C_NUM_PORTS*C_PKT_EMPTY_WIDTH-1:0]  in_empty,
  output logic [C_NUM_PORTS-1:0]                    in_ready,
  output logic                                      out_valid,
  output logic                                      out_startofpacket,
  output logic                                      out_endofpacket,
  output logic                                      out_error,
  output logic [C_PKT_DATA_WIDTH-1:0]               out_data,
  output logic [C_PKT_EMPTY_WIDTH-1:0]              out_empty,
  input  logic                                      out_ready,
  output logic [C_PORT_WIDTH-1:0]                   out_port,
  output logic [C_DROP_CNT_WIDTH-1:0]               drop_cnt
);

  localparam int C_SUM_WIDTH = C_DROP_CNT_WIDTH + 4;

  t_state                       state_r;
  t_state                       state_nxt_s;
  logic [C_PORT_WIDTH-1:0]      grant_r;
  logic [C_NUM_PORTS-1:0]       grant_oh_r;
  logic [C_PORT_WIDTH-1:0]      last_r;
  logic                         first_r;

  logic [C_NUM_PORTS-1:0]       cand_s;
  logic [C_NUM_PORTS-1:0]       orphan_s;
  logic [C_NUM_PORTS-1:0]       gnt_oh_s;
  logic [C_PORT_WIDTH-1:0]      gnt_idx_s;
  logic                         gnt_any_s;
  logic                         arb_load_s;
  logic                         slot_free_s;
  logic                         xfer_s;

  logic                         sel_vld_s;
  logic                         sel_sop_s;
  logic                         sel_eop_s;
  logic                         sel_err_s;
  logic [C_PKT_DATA_WIDTH-1:0]  sel_data_s;
  logic [C_PKT_EMPTY_WIDTH-1:0] sel_empty_s;

  logic [3:0]                   drop_inc_s;
  logic [C_SUM_WIDTH-1:0]       drop_sum_s;
  logic [C_DROP_CNT_WIDTH-1:0]  drop_nxt_s;

  assign cand_s      = in_valid & in_startofpacket;
  assign orphan_s    = in_valid & ~in_startofpacket;
  assign slot_free_s = ~out_valid | out_ready;
  assign arb_load_s  = (state_r == ST_IDLE) & gnt_any_s;
  assign xfer_s      = (state_r == ST_ACTIVE) & sel_vld_s & slot_free_s;

  rr_arbiter #(
    .C_NUM_PORTS (C_NUM_PORTS),
    .C_IDX_WIDTH (C_PORT_WIDTH)
  ) u_rr (
    .req        (cand_s),
    .last       (last_r),
    .gnt_onehot (gnt_oh_s),
    .gnt_idx    (gnt_idx_s),
    .gnt_any    (gnt_any_s)
  );

  // Ready: orphans are swallowed while idle, only the owner may advance while active.
  always_comb begin
    in_ready = '0;
    if (reset) begin
      in_ready = '0;
    end else begin
      case (state_r)
        ST_IDLE:   in_ready = orphan_s;
        ST_ACTIVE: in_ready = grant_oh_r & {C_NUM_PORTS{slot_free_s}};
        default:   in_ready = '0;
      endcase
    end
  end

  // AND-OR mux of the granted port's beat; grant_oh_r is always one-hot.
  always_comb begin
    sel_vld_s   = 1'b0;
    sel_sop_s   = 1'b0;
    sel_eop_s   = 1'b0;
    sel_err_s   = 1'b0;
    sel_data_s  = '0;
    sel_empty_s = '0;
    for (int p = 0; p < C_NUM_PORTS; p++) begin
      sel_vld_s   = sel_vld_s | (in_valid[p] & grant_oh_r[p]);
      sel_sop_s   = sel_sop_s | (in_startofpacket[p] & grant_oh_r[p]);
      sel_eop_s   = sel_eop_s | (in_endofpacket[p] & grant_oh_r[p]);
      sel_err_s   = sel_err_s | (in_error[p] & grant_oh_r[p]);
      sel_data_s  = sel_data_s |
                    (in_data[p*C_PKT_DATA_WIDTH +: C_PKT_DATA_WIDTH] & {C_PKT_DATA_WIDTH{grant_oh_r[p]}});
      sel_empty_s = sel_empty_s |
                    (in_empty[p*C_PKT_EMPTY_WIDTH +: C_PKT_EMPTY_WIDTH] & {C_PKT_EMPTY_WIDTH{grant_oh_r[p]}});
    end
  end

  // Next-state: leave ACTIVE right after the end-of-packet beat is taken.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_any_s) begin
          state_nxt_s = ST_ACTIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (xfer_s && sel_eop_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Number of orphan beats swallowed this cycle, added with saturation.
  always_comb begin
    drop_inc_s = 4'd0;
    drop_nxt_s = drop_cnt;
    for (int p = 0; p < C_NUM_PORTS; p++) begin
      drop_inc_s = drop_inc_s + 4'((state_r == ST_IDLE) & orphan_s[p]);
    end
    drop_sum_s = C_SUM_WIDTH'(drop_cnt) + C_SUM_WIDTH'(drop_inc_s);
    if (drop_sum_s > C_SUM_WIDTH'({C_DROP_CNT_WIDTH{1'b1}})) begin
      drop_nxt_s = '1;
    end else begin
      drop_nxt_s = drop_sum_s[C_DROP_CNT_WIDTH-1:0];
    end
  end

  // FSM state, grant and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      grant_r    <= '0;
      grant_oh_r <= {{(C_NUM_PORTS-1){1'b0}}, 1'b1};
      last_r     <= C_PORT_WIDTH'(C_NUM_PORTS - 1);
      first_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (arb_load_s) begin
        grant_r    <= gnt_idx_s;
        grant_oh_r <= gnt_oh_s;
        last_r     <= gnt_idx_s;
        first_r    <= 1'b1;
      end else if (xfer_s) begin
        first_r <= 1'b0;
      end
    end
  end

  // Single output register stage; a second sop inside a packet is flagged as an error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_error         <= 1'b0;
      out_data          <= '0;
      out_empty         <= '0;
      out_port          <= '0;
    end else if (xfer_s) begin
      out_valid         <= 1'b1;
      out_startofpacket <= sel_sop_s;
      out_endofpacket   <= sel_eop_s;
      out_error         <= sel_err_s | (sel_sop_s & ~first_r);
      out_data          <= sel_data_s;
      out_empty         <= sel_empty_s;
      out_port          <= grant_r;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Orphan-beat drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_nxt_s;
    end
  end

endmodule

// File: tb/tb_feed_arbiter.sv
// Randomised and directed bench for feed_arbiter against a transaction-level reference model.
module tb_feed_arbiter;
  import feed_pkg::*;

  localparam int NP     = 4;
  localparam int DW     = C_PKT_DATA_WIDTH_DEF;
  localparam int EW     = C_PKT_EMPTY_WIDTH_DEF;
  localparam int MAXCNT = 65535;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]    in_valid = '0, in_sop = '0, in_eop = '0, in_err = '0;
  logic [NP*DW-1:0] in_data  = '0;
  logic [NP*EW-1:0] in_empty = '0;
  logic             out_ready = 1'b0;

  logic [NP-1:0] rdy_a, rdy_b;
  logic          ov_a, os_a, oe_a, oerr_a, ov_b, os_b, oe_b, oerr_b;
  logic [DW-1:0] od_a, od_b;
  logic [EW-1:0] oemt_a, oemt_b;
  logic [1:0]    op_a, op_b;
  logic [15:0]   drop_a;
  logic [1:0]    drop_b;

  feed_arbiter u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_startofpacket(in_sop),
    .in_endofpacket(in_eop), .in_error(in_err), .in_data(in_data), .in_empty(in_empty),
    .in_ready(rdy_a), .out_valid(ov_a), .out_startofpacket(os_a), .out_endofpacket(oe_a),
    .out_error(oerr_a), .out_data(od_a), .out_empty(oemt_a), .out_ready(out_ready),
    .out_port(op_a), .drop_cnt(drop_a)
  );

  feed_arbiter #(.C_DROP_CNT_WIDTH(2)) u_dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_startofpacket(in_sop),
    .in_endofpacket(in_eop), .in_error(in_err), .in_data(in_data), .in_empty(in_empty),
    .in_ready(rdy_b), .out_valid(ov_b), .out_startofpacket(os_b), .out_endofpacket(oe_b),
    .out_error(oerr_b), .out_data(od_b), .out_empty(oemt_b), .out_ready(out_ready),
    .out_port(op_b), .drop_cnt(drop_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: who owns the output, round-robin pointer, beats taken in open packet
  bit            m_active;
  int            m_owner;
  int            m_last;
  int            m_beats;
  t_pkt          m_o;
  int            m_port;
  int            m_drops;
  logic [NP-1:0] m_rdy;

  t_pkt pq[NP][$];
  t_pkt log_b[$];
  int   log_port[$];
  int   log_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [63:0] mk_dat(input int p, input int id, input int i);
    return {32'(p), 16'(id), 16'(i)};
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_owner  = 0;
    m_last   = NP - 1;
    m_beats  = 0;
    m_o      = '0;
    m_port   = 0;
    m_drops  = 0;
  endtask

  task automatic push_beat(input int p, input bit sop, input bit eop, input logic [63:0] dat,
                           input int emt, input bit err);
    t_pkt b;
    b.vld = 1'b1; b.sop = sop; b.eop = eop; b.dat = dat; b.emt = EW'(emt); b.err = err;
    pq[p].push_back(b);
  endtask

  task automatic add_pkt(input int p, input int len, input int id);
    for (int i = 0; i < len; i++) push_beat(p, i == 0, i == len - 1, mk_dat(p, id, i), 0, 1'b0);
  endtask

  task automatic clear_log();
    log_b.delete(); log_port.delete(); log_cyc.delete();
  endtask

  // advance the model by one rising edge given the inputs currently applied
  task automatic model_clock();
    bit   found;
    int   p;
    t_pkt b;
    if (!m_active) begin
      for (int q = 0; q < NP; q++) begin
        if (m_rdy[q] && in_valid[q]) begin
          m_drops++;
          void'(pq[q].pop_front());
        end
      end
      if (out_ready) m_o.vld = 1'b0;
      found = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        p = (m_last + k) % NP;
        if (!found && in_valid[p] && in_sop[p]) begin
          found = 1'b1; m_owner = p; m_last = p; m_active = 1'b1; m_beats = 0;
        end
      end
    end else if (in_valid[m_owner] && m_rdy[m_owner]) begin
      b = pq[m_owner].pop_front();
      m_o = b;
      m_o.err = b.err | (b.sop && m_beats > 0);
      m_port = m_owner;
      m_beats++;
      if (b.eop) m_active = 1'b0;
    end else if (out_ready) begin
      m_o.vld = 1'b0;
    end
  endtask

  // one clock: drive at negedge, compare 1ns later, then step the model
  task automatic step(input bit gaps, input int rmode);
    t_pkt b;
    @(negedge clk);
    reset = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (pq[p].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        b = pq[p][0];
        in_valid[p] = 1'b1; in_sop[p] = b.sop; in_eop[p] = b.eop; in_err[p] = b.err;
        in_data[p*DW +: DW] = b.dat; in_empty[p*EW +: EW] = b.emt;
      end else begin
        in_valid[p] = 1'b0; in_sop[p] = 1'($urandom); in_eop[p] = 1'($urandom);
        in_err[p] = 1'($urandom); in_data[p*DW +: DW] = {$urandom, $urandom};
        in_empty[p*EW +: EW] = EW'($urandom);
      end
    end
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 2 == 0);
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    #1;
    check("out_valid", ov_a, m_o.vld);
    check("out_valid_sat", ov_b, m_o.vld);
    if (m_o.vld) begin
      check("out_sop", os_a, m_o.sop);
      check("out_eop", oe_a, m_o.eop);
      check("out_error", oerr_a, m_o.err);
      check("out_data", od_a, m_o.dat);
      check("out_empty", oemt_a, m_o.emt);
      check("out_port", op_a, m_port);
      check("out_data_sat", od_b, m_o.dat);
    end
    check("drop_cnt", drop_a, sat(m_drops, MAXCNT));
    check("drop_cnt_sat", drop_b, sat(m_drops, 3));
    m_rdy = '0;
    if (!m_active) begin
      for (int p = 0; p < NP; p++) m_rdy[p] = in_valid[p] & ~in_sop[p];
    end else begin
      m_rdy[m_owner] = ~m_o.vld | out_ready;
    end
    check("in_ready", rdy_a, m_rdy);
    check("in_ready_sat", rdy_b, m_rdy);
    if (ov_a && out_ready) begin
      b.vld = ov_a; b.sop = os_a; b.eop = oe_a; b.err = oerr_a; b.dat = od_a; b.emt = oemt_a;
      log_b.push_back(b); log_port.push_back(int'(op_a)); log_cyc.push_back(cyc);
    end
    model_clock();
    cyc++;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_out_valid", ov_a, 1'b0);
    check("rst_out_flags", {os_a, oe_a, oerr_a}, 3'b000);
    check("rst_out_data", od_a, 64'd0);
    check("rst_out_empty", oemt_a, 3'd0);
    check("rst_out_port", op_a, 2'd0);
    check("rst_drop_cnt", drop_a, 16'd0);
    check("rst_in_ready", rdy_a, 4'd0);
    model_reset();
    clear_log();
  endtask

  int t0;
  int r;
  int n;

  initial begin
    model_reset();

    // four 3-beat packets at once: served 0,1,2,3 with one idle cycle between
    reset_pulse();
    for (int p = 0; p < NP; p++) add_pkt(p, 3, p + 1);
    t0 = cyc;
    repeat (24) step(1'b0, 0);
    check("rr_beat_count", log_b.size(), 12);
    if (log_b.size() == 12) begin
      check("rr_first_latency", log_cyc[0] - t0, 2);
      for (int k = 0; k < NP; k++) begin
        check("rr_order", log_port[3*k], k);
        check("rr_sop", log_b[3*k].sop, 1'b1);
        check("rr_eop", log_b[3*k+2].eop, 1'b1);
        check("rr_data", log_b[3*k+1].dat, mk_dat(k, k + 1, 1));
        if (k > 0) check("rr_gap", log_cyc[3*k] - log_cyc[3*k-3], 4);
      end
    end

    // 4-beat packet on port 2 with out_ready toggling
    reset_pulse();
    add_pkt(2, 4, 7);
    repeat (20) step(1'b0, 1);
    check("stall_beat_count", log_b.size(), 4);
    if (log_b.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("stall_data", log_b[i].dat, mk_dat(2, 7, i));
        check("stall_port", log_port[i], 2);
      end
    end

    // single-beat packets on ports 1 and 2: port 2 follows two cycles later
    reset_pulse();
    push_beat(1, 1'b1, 1'b1, 64'h1111, 3, 1'b0);
    push_beat(2, 1'b1, 1'b1, 64'h2222, 0, 1'b0);
    repeat (10) step(1'b0, 0);
    check("single_count", log_b.size(), 2);
    if (log_b.size() == 2) begin
      check("single_port", log_port[0], 1);
      check("single_sop_eop", {log_b[0].sop, log_b[0].eop}, 2'b11);
      check("single_empty", log_b[0].emt, 3'd3);
      check("single_next_gap", log_cyc[1] - log_cyc[0], 2);
    end

    // five orphan beats on port 3
    reset_pulse();
    for (int i = 0; i < 5; i++) push_beat(3, 1'b0, 1'b0, mk_dat(3, 0, i), 0, 1'b0);
    repeat (8) step(1'b0, 0);
    check("orphan_drop", drop_a, 16'd5);
    check("orphan_drop_sat", drop_b, 2'd3);
    check("orphan_no_output", log_b.size(), 0);

    // stray sop inside a packet is flagged
    reset_pulse();
    push_beat(0, 1'b1, 1'b0, 64'hA0, 0, 1'b0);
    push_beat(0, 1'b0, 1'b0, 64'hA1, 0, 1'b0);
    push_beat(0, 1'b1, 1'b0, 64'hA2, 0, 1'b0);
    push_beat(0, 1'b0, 1'b1, 64'hA3, 0, 1'b0);
    repeat (12) step(1'b0, 0);
    check("midsop_count", log_b.size(), 4);
    if (log_b.size() == 4) begin
      check("midsop_errs", {log_b[0].err, log_b[1].err, log_b[2].err, log_b[3].err}, 4'b0010);
    end

    // reset during a port-1 packet: tail is dropped, next packet is normal
    reset_pulse();
    add_pkt(1, 4, 9);
    n = 0;
    while (pq[1].size() > 2 && n < 20) begin
      step(1'b0, 0);
      n++;
    end
    check("midrst_reached", pq[1].size(), 2);
    reset_pulse();
    repeat (6) step(1'b0, 0);
    check("midrst_drop", drop_a, 16'd2);
    check("midrst_no_output", log_b.size(), 0);
    add_pkt(1, 2, 10);
    repeat (8) step(1'b0, 0);
    check("midrst_next_count", log_b.size(), 2);
    if (log_b.size() == 2) begin
      check("midrst_next_port", log_port[0], 1);
      check("midrst_next_sop", log_b[0].sop, 1'b1);
      check("midrst_next_err", log_b[0].err, 1'b0);
      check("midrst_next_data", log_b[1].dat, mk_dat(1, 10, 1));
    end

    // random traffic, gaps, back-pressure, orphans and stray sops
    reset_pulse();
    for (int c = 0; c < 2500; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (pq[p].size() == 0 && $urandom_range(0, 5) == 0) begin
          r = $urandom_range(0, 7);
          n = $urandom_range(1, 5);
          if (r == 0) begin
            push_beat(p, 1'b0, 1'($urandom), {$urandom, $urandom}, $urandom_range(0, 7), 1'($urandom));
          end else begin
            for (int i = 0; i < n; i++) begin
              push_beat(p, (i == 0) || (r == 1 && i == 2), i == n - 1, {$urandom, $urandom},
                        (i == n - 1) ? $urandom_range(0, 7) : 0, $urandom_range(0, 7) == 0);
            end
          end
        end
      end
      step(1'b1, 2);
    end
    n = 0;
    while ((pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size() > 0 || m_o.vld) && n < 400) begin
      step(1'b0, 0);
      n++;
    end
    check("drain_done", pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
